writeback_unit: RTL and testbench
=================================

# writeback_unit

Register-file write-side controller for the RISC-V core, driving the `en`/`rd`/write-data inputs of `register_file`. It merges ALU results and load responses onto the single register-file write port. Load data passes through a small FIFO, and a starvation counter guarantees loads eventually drain. It also keeps a pending-load scoreboard that decode uses to stall on RAW/WAW hazards.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register index width
- `FIFO_DEPTH`, 2, load-buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 3, consecutive ALU-won cycles tolerated while the FIFO is non-empty

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `alu_valid`  in  1  ALU result available
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_rd`  in  ADDR_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `mem_valid`  in  1  load response available
- `mem_ready`  out  1  load buffer can accept
- `mem_rd`  in  ADDR_WIDTH  load destination register
- `mem_data`  in  DATA_WIDTH  load data
- `issue_load`  in  1  decode issued a load this cycle
- `issue_rd`  in  ADDR_WIDTH  destination of the issued load
- `en`  out  1  register-file write enable
- `rd`  out  ADDR_WIDTH  register-file write address
- `write_data`  out  DATA_WIDTH  register-file write data
- `pending`  out  2**ADDR_WIDTH  bit i set means a load to xi is outstanding

## Operation
- ALU handshake: transfer when `alu_valid && alu_ready`. A transfer with `alu_rd != 0` claims the write port this cycle.
- Load handshake: push when `mem_valid && mem_ready`. `mem_ready = !full && !rst`.
- Port arbitration each cycle:
  - An accepted ALU write to a nonzero register wins.
  - Otherwise a non-empty FIFO pops its head into the write port.
  - Otherwise there is no write.
- x0: writes with rd = 0 are accepted and dropped (`en` stays 0). An ALU rd = 0 transfer does not claim the port. A load with rd = 0 is still pushed and popped but produces no write.
- Scoreboard:
  - `issue_load && issue_rd != 0` sets `pending[issue_rd]`.
  - Popping a FIFO entry clears `pending[entry.rd]`.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
- ALU write to a register with its pending bit set: the write proceeds and the bit is unchanged. Avoiding this is decode's responsibility.
- Starvation FSM (states NORMAL, DRAIN):
  - NORMAL: `alu_ready = 1`. `starve_cnt` increments when the FIFO is non-empty and the ALU claims the port. It resets to 0 when the FIFO pops or the FIFO is empty.
  - NORMAL → DRAIN when `starve_cnt` reaches `STARVE_LIMIT` and the FIFO is non-empty.
  - DRAIN: `alu_ready = 0`; the head pops; `starve_cnt` is set to 0. Next state is always NORMAL (exactly one cycle).
- FIFO: simultaneous push and pop is allowed when non-empty. Pointers wrap modulo `FIFO_DEPTH`. Order is strictly FIFO.

## Timing
- Write latency: one cycle. `en`/`rd`/`write_data` are registered and reflect the winner of the previous cycle. `en` is high exactly one cycle per write.
- A pending bit clears on the same edge that registers the corresponding `en`.
- Minimum load latency: pushed in cycle N, popped in N+1 if the port is free, `en` in N+2.
- `mem_ready`, `alu_ready` and the pending bits are derived from registered state only. There are no combinational paths from `*_valid` to `*_ready`.
- Reset values: `en` = 0, `rd` = 0, `write_data` = 0, `pending` = 0, FIFO empty, `starve_cnt` = 0, state NORMAL.
  - During `rst`, `alu_ready` = 0 and `mem_ready` = 0.
  - Both are 1 in the first cycle after `rst` falls.
- Reset mid-operation discards FIFO contents and pending bits. No write is issued on the following cycle.

## Structure
- Package `wb_pkg`: `wb_state_e` {NORMAL, DRAIN}; packed struct `wb_entry_t` {rd, data}; width constants.
- Sub-module `wb_load_fifo`: parameterised synchronous FIFO with push/pop/full/empty/head.
- The top level holds arbitration, the FSM, the scoreboard and the output registers.

## Test plan
- Reset, then ALU writes x5 = 0xDEADBEEF: `en` = 1, `rd` = 5, `write_data` = 0xDEADBEEF one cycle later. Immediately after reset, `alu_ready` = `mem_ready` = 1.
- `issue_load` x7; load x7 = 0x1234 arrives with ALU idle: `pending[7]` set; `en` at push+2 with `rd` = 7; `pending[7]` clears on that edge.
- ALU valid every cycle to x1 while loads to x2 and x3 arrive:
  - after 3 ALU-won cycles, `alu_ready` = 0 for one cycle and x2 is written;
  - after 3 more ALU-won cycles, x3 is written;
  - order is preserved.
- FIFO full (two loads buffered, ALU busy): `mem_ready` = 0; a held `mem_valid` is accepted only after a pop; no data lost.
- ALU and load with rd = 0: no `en` pulse; an ALU rd = 0 transfer lets the FIFO pop that cycle; `pending[0]` stays 0.
- `issue_load` x9 on the same cycle a buffered x9 load pops: `pending[9]` remains 1. Assert `rst` with the FIFO non-empty: `pending` = 0, no `en` afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and width constants for the register-file writeback unit.
//   wb_state_e : starvation FSM states (NORMAL, DRAIN)
//   wb_entry_t : one buffered load response {rd, data} at the default widths
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: synchronous FIFO buffering load responses for the writeback port.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  : write one entry (ignored when full)
//   i_pop           : drop the head entry (ignored when empty)
//   o_full, o_empty : occupancy flags, registered state only
//   o_head          : oldest entry, valid while !o_empty
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_load_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and buffered load responses onto the single
// register-file write port, and tracks outstanding loads for decode hazard stalls.
//   clk, rst                          : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data : load response handshake (into FIFO)
//   issue_load, issue_rd              : decode issued a load to issue_rd
//   en, rd, write_data                : registered register-file write port
//   pending                           : bit i set while a load to xi is outstanding
//
// Starvation FSM
//   state  | meaning
//   NORMAL | ALU has priority; counts consecutive ALU wins over a waiting load
//   DRAIN  | ALU stalled for one cycle so the FIFO head is written
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int ADDR_WIDTH   = WB_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_WIDTH-1:0]    mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     issue_load,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic                     en,
  output logic [ADDR_WIDTH-1:0]    rd,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [2**ADDR_WIDTH-1:0] pending
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

  // Entry layout follows the instance widths rather than the package defaults.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  wb_state_e           r_state;
  logic [CW-1:0]       r_starve_cnt;
  logic                r_en;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NREG-1:0]     r_pending;

  logic                w_full;
  logic                w_empty;
  entry_t              w_head;
  entry_t              w_push_entry;
  logic                w_alu_claim;
  logic                w_push;
  logic                w_pop;
  logic [NREG-1:0]     w_pend_next;

  assign alu_ready    = !rst && (r_state == NORMAL);
  assign mem_ready    = !rst && !w_full;
  assign w_alu_claim  = alu_valid && alu_ready && (alu_rd != '0);
  assign w_push       = mem_valid && mem_ready;
  // DRAIN forces alu_ready low, so the head always pops there.
  assign w_pop        = !w_empty && !w_alu_claim && !rst;
  assign w_push_entry = '{rd: mem_rd, data: mem_data};

  assign en         = r_en;
  assign rd         = r_rd;
  assign write_data = r_wdata;
  assign pending    = r_pending;

  wb_load_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_load_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Clear before set so an issue on the popping register keeps it pending.
  always_comb begin
    w_pend_next = r_pending;
    if (w_pop) w_pend_next[w_head.rd] = 1'b0;
    if (issue_load) w_pend_next[issue_rd] = 1'b1;
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
      r_en         <= 1'b0;
      r_rd         <= '0;
      r_wdata      <= '0;
      r_pending    <= '0;
    end else begin
      r_pending <= w_pend_next;

      r_en <= 1'b0;
      if (w_alu_claim) begin
        r_en    <= 1'b1;
        r_rd    <= alu_rd;
        r_wdata <= alu_data;
      end else if (w_pop && (w_head.rd != '0)) begin
        r_en    <= 1'b1;
        r_rd    <= w_head.rd;
        r_wdata <= w_head.data;
      end

      case (r_state)
        NORMAL: begin
          // A claim with a waiting load cannot pop, so the FIFO stays non-empty.
          if (w_alu_claim && !w_empty) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
            if (r_starve_cnt == LIMIT_M1) r_state <= DRAIN;
          end else begin
            r_starve_cnt <= '0;
          end
        end
        DRAIN: begin
          r_state      <= NORMAL;
          r_starve_cnt <= '0;
        end
        default: begin
          r_state      <= NORMAL;
          r_starve_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          issue_load;
  logic [AW-1:0] issue_rd;
  logic          en;
  logic [AW-1:0] rd;
  logic [DW-1:0] write_data;
  logic [31:0]   pending;

  writeback_unit #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .issue_load (issue_load),
    .issue_rd   (issue_rd),
    .en         (en),
    .rd         (rd),
    .write_data (write_data),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered loads, a count of consecutive cycles in
  // which the ALU took the port while a load waited, and a set of pending regs.
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } load_t;

  load_t         q[$];
  int            streak;
  bit   [31:0]   m_pend;
  logic          exp_en;
  logic [AW-1:0] exp_rd;
  logic [DW-1:0] exp_wd;
  bit            chk_rdwd;
  bit            m_pushed;
  int            cyc;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    rst        = 1'b0;
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    mem_valid  = 1'b0;
    mem_rd     = '0;
    mem_data   = '0;
    issue_load = 1'b0;
    issue_rd   = '0;
  endtask

  task automatic alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
    alu_valid = 1'b1;
    alu_rd    = r;
    alu_data  = d;
  endtask

  task automatic load(input logic [AW-1:0] r, input logic [DW-1:0] d);
    mem_valid = 1'b1;
    mem_rd    = r;
    mem_data  = d;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    issue_load = 1'b1;
    issue_rd   = r;
  endtask

  // One clock: check readies, advance the model, then check the registered port.
  task automatic step();
    logic exp_ar, exp_mr, claim, pop;
    #1;
    if (rst) begin
      exp_ar = 1'b0;
      exp_mr = 1'b0;
    end else begin
      exp_ar = (streak < LIMIT);
      exp_mr = (q.size() < DEPTH);
    end
    chk("alu_ready", alu_ready, exp_ar);
    chk("mem_ready", mem_ready, exp_mr);
    m_pushed = 1'b0;
    if (rst) begin
      q.delete();
      streak   = 0;
      m_pend   = '0;
      exp_en   = 1'b0;
      exp_rd   = '0;
      exp_wd   = '0;
      chk_rdwd = 1'b1;
    end else begin
      claim  = alu_valid && exp_ar && (alu_rd != 0);
      pop    = (q.size() > 0) && !claim;
      exp_en = 1'b0;
      if (claim) begin
        exp_en = 1'b1;
        exp_rd = alu_rd;
        exp_wd = alu_data;
      end else if (pop && q[0].rd != 0) begin
        exp_en = 1'b1;
        exp_rd = q[0].rd;
        exp_wd = q[0].data;
      end
      chk_rdwd = exp_en;
      if (pop) m_pend[q[0].rd] = 1'b0;
      if (issue_load && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      if (!exp_ar) streak = 0;
      else if (claim && q.size() > 0) streak++;
      else streak = 0;
      if (pop) void'(q.pop_front());
      if (mem_valid && exp_mr) begin
        q.push_back('{rd: mem_rd, data: mem_data});
        m_pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("en", en, exp_en);
    if (chk_rdwd) begin
      chk("rd", rd, exp_rd);
      chk("write_data", write_data, exp_wd);
    end
    chk("pending", pending, m_pend);
    cyc++;
  endtask

  initial begin
    bit got;
    cyc    = 0;
    streak = 0;
    m_pend = '0;

    // Reset, then first cycle out of reset has both readies high.
    idle(); rst = 1'b1; step(); step();
    idle(); step();

    // ALU write x5 = DEADBEEF.
    alu(5, 32'hDEADBEEF); step();
    idle(); step();
    chk("x5_rd_hold", rd, 5'd5);

    // Issue x7, then load x7 with the ALU idle: write two cycles after push.
    idle(); issue(7); step();
    idle(); load(7, 32'h1234); step();
    chk("x7_pending_set", pending[7], 1'b1);
    idle(); step();
    idle(); step();
    chk("x7_written", {en, rd}, {1'b0, 5'd7});
    idle(); step();

    // Continuous ALU x1 while loads x2 and x3 arrive: periodic drain.
    for (int i = 0; i < 12; i++) begin
      idle();
      alu(1, 32'h100 + i);
      if (i == 0) begin load(2, 32'h2222); issue(2); end
      if (i == 1) begin load(3, 32'h3333); issue(3); end
      step();
    end
    idle(); step();

    // FIFO full with ALU busy; x12 held until accepted.
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle();
      alu(1, 32'h200 + i);
      if (i == 0) load(10, 32'hA0A0);
      else if (i == 1) load(11, 32'hB1B1);
      else if (!got) load(12, 32'hC2C2);
      step();
      if (i >= 2 && m_pushed) got = 1'b1;
    end
    chk("x12_accepted", got, 1'b1);
    for (int i = 0; i < 4; i++) begin idle(); step(); end

    // x0 traffic: ALU rd0 frees the port for the buffered load.
    idle(); alu(1, 32'h11); load(4, 32'h4444); step();
    idle(); alu(0, 32'h55); load(0, 32'h66); issue(0); step();
    idle(); step();
    idle(); step();
    chk("pending0", pending[0], 1'b0);

    // Re-issue x9 as its buffered load pops: bit stays set.
    idle(); issue(9); step();
    idle(); alu(1, 32'h77); load(9, 32'h9999); step();
    idle(); issue(9); step();
    chk("x9_still_pending", pending[9], 1'b1);
    idle(); step();

    // Reset with the FIFO non-empty.
    idle(); alu(1, 32'h88); load(6, 32'h6666); issue(6); step();
    idle(); alu(1, 32'h89); step();
    idle(); rst = 1'b1; step();
    chk("rst_pending", pending, 32'h0);
    for (int i = 0; i < 4; i++) begin idle(); step(); end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      idle();
      rst        = ($urandom_range(0, 79) == 0);
      alu_valid  = ($urandom_range(0, 3) != 0);
      alu_rd     = AW'($urandom_range(0, 7));
      alu_data   = $urandom;
      mem_valid  = ($urandom_range(0, 1) == 1);
      mem_rd     = AW'($urandom_range(0, 31));
      mem_data   = $urandom;
      issue_load = ($urandom_range(0, 2) == 0);
      issue_rd   = AW'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
